// File: rtl/seed_fiao_ctrl.sv
// Seed collection controller: gathers CHUNKS entropy words into an external
// accumulator, offers the full seed, and discards batches hit by health failures.
module seed_fiao_ctrl #(
  parameter int ENQ_WIDTH = 32,
  parameter int CHUNKS    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 src_valid,
  input  logic [ENQ_WIDTH-1:0] src_data,
  output logic                 src_ready,
  input  logic                 hlth_fail,
  output logic [ENQ_WIDTH-1:0] buf_wdata,
  output logic                 buf_enque,
  output logic                 buf_deque,
  input  logic                 buf_full,
  input  logic                 buf_empty,
  output logic                 seed_valid,
  input  logic                 seed_ready,
  output logic [15:0]          seed_cnt,
  output logic [7:0]           drop_cnt,
  output logic                 busy,
  output logic                 sync_err
);

  localparam int CW = $clog2(CHUNKS + 1);
  localparam logic [CW-1:0] FULL = CW'(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    OFFER,
    DRAIN
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] fill_cnt, fill_nx;
  logic [15:0]   seed_nx;
  logic [7:0]    drop_nx;
  logic          at_full;

  assign at_full    = (fill_cnt == FULL);
  assign buf_wdata  = src_data;
  assign src_ready  = ((state == FILL) && en)
                    || ((state == DRAIN) && !at_full);
  assign buf_enque  = src_valid & src_ready;
  assign seed_valid = (state == OFFER) && buf_full;
  // A poisoned full batch is flushed with seed_valid held low
  assign buf_deque  = (seed_valid && seed_ready)
                    || ((state == DRAIN) && at_full);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
      seed_cnt <= '0;
      drop_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      seed_cnt <= seed_nx;
      drop_cnt <= drop_nx;
      if ((buf_full != at_full) || (buf_empty != (fill_cnt == '0)))
        sync_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    seed_nx  = seed_cnt;
    drop_nx  = drop_cnt;
    if (buf_enque)
      fill_nx = fill_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (en && buf_empty)
          state_nx = FILL;
      end
      FILL: begin
        if (hlth_fail)
          state_nx = DRAIN;
        else if (buf_enque && (fill_cnt == LAST))
          state_nx = OFFER;
      end
      OFFER: begin
        // A handoff takes priority over a same-cycle health failure
        if (buf_deque) begin
          fill_nx  = '0;
          state_nx = en ? FILL : IDLE;
          if (seed_cnt != 16'hFFFF)
            seed_nx = seed_cnt + 16'd1;
        end else if (hlth_fail) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (at_full) begin
          fill_nx  = '0;
          state_nx = en ? FILL : IDLE;
          if (drop_cnt != 8'hFF)
            drop_nx = drop_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seed_fiao_ctrl.sv
// Bench for seed_fiao_ctrl: behavioural batch model with a seed scoreboard,
// directed scenarios followed by randomized traffic.
module tb_seed_fiao_ctrl;

  localparam int W = 32;
  localparam int N = 12;

  logic clk = 0;
  logic rst_n = 1;
  logic en = 0, src_valid = 0, hlth_fail = 0, seed_ready = 0;
  logic [W-1:0] src_data = '0;
  logic src_ready, buf_enque, buf_deque, buf_full, buf_empty;
  logic seed_valid, busy, sync_err;
  logic [W-1:0] buf_wdata;
  logic [15:0] seed_cnt;
  logic [7:0] drop_cnt;
  logic force_full = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seed_fiao_ctrl #(.ENQ_WIDTH(W), .CHUNKS(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .hlth_fail(hlth_fail),
    .buf_wdata(buf_wdata), .buf_enque(buf_enque), .buf_deque(buf_deque),
    .buf_full(buf_full), .buf_empty(buf_empty),
    .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_cnt(seed_cnt), .drop_cnt(drop_cnt),
    .busy(busy), .sync_err(sync_err)
  );

  // Accumulator stand-in, reset from the same rst_n
  logic [W-1:0] acc[$];
  int acc_n = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc.delete();
      acc_n <= 0;
    end else if (buf_deque) begin
      acc.delete();
      acc_n <= 0;
    end else if (buf_enque) begin
      acc.push_back(buf_wdata);
      acc_n <= acc_n + 1;
    end
  end
  assign buf_full  = (acc_n == N) ^ force_full;
  assign buf_empty = (acc_n == 0);

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a batch of collected chunks, poisoned or not
  logic [W-1:0] batch[$];
  logic [N*W-1:0] sb[$];
  bit m_active, m_doomed, m_sync;
  int m_seed, m_drop;

  always @(negedge clk) begin : model
    bit rdy_e, val_e, deq_e, enq_e;
    logic [N*W-1:0] s;
    if (!rst_n) begin
      batch.delete();
      sb.delete();
      m_active = 0;
      m_doomed = 0;
      m_sync = 0;
      m_seed = 0;
      m_drop = 0;
    end
    rdy_e = m_active && batch.size() < N && (m_doomed || en);
    val_e = m_active && !m_doomed && batch.size() == N;
    deq_e = m_active && batch.size() == N && (m_doomed || seed_ready);
    enq_e = src_valid && rdy_e;
    check("outputs",
          64'({src_ready, buf_enque, buf_deque, seed_valid, busy, sync_err}),
          64'({rdy_e, enq_e, deq_e, val_e, m_active, m_sync}));
    check("counts", 64'({seed_cnt, drop_cnt}),
          64'({m_seed[15:0], m_drop[7:0]}));
    check("wdata", 64'(buf_wdata), 64'(src_data));
    if (rst_n) begin
      if ((buf_full != (batch.size() == N)) ||
          (buf_empty != (batch.size() == 0)))
        m_sync = 1;
      if (!m_active) begin
        if (en && buf_empty) m_active = 1;
      end else begin
        if (enq_e) batch.push_back(src_data);
        if (deq_e) begin
          if (!m_doomed) begin
            s = '0;
            foreach (batch[i]) s[i*W +: W] = batch[i];
            sb.push_back(s);
            if (m_seed < 65535) m_seed++;
          end else if (m_drop < 255) begin
            m_drop++;
          end
          batch.delete();
          m_doomed = 0;
          m_active = en;
        end else if (hlth_fail) begin
          m_doomed = 1;
        end
      end
    end
  end

  // Monitor: compares each delivered seed with the scoreboard head
  always @(negedge clk) begin : monitor
    logic [N*W-1:0] got, exp;
    #1;
    if (rst_n && buf_deque && seed_valid) begin
      got = '0;
      foreach (acc[i]) got[i*W +: W] = acc[i];
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL seed_unexpected: got %0h expected none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL seed_data: got %0h expected %0h", got, exp);
        end
      end
    end
  end

  task automatic tick(input bit e, input bit v, input bit r, input bit h);
    en = e;
    src_valid = v;
    seed_ready = r;
    hlth_fail = h;
    src_data = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) tick(0, 0, 0, 0);
    rst_n = 1;
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    check("reset_outputs",
          64'({src_ready, buf_enque, buf_deque, seed_valid, busy,
               sync_err, seed_cnt, drop_cnt}), 64'(0));
    do_reset();

    // Scenario 1: streaming with a ready consumer
    repeat (14) tick(1, 1, 1, 0);
    check("s1_seed_cnt", 64'(seed_cnt), 64'(1));
    check("s1_resume", 64'(src_ready), 64'(1));

    // Scenario 2: consumer stalls for 20 cycles
    do_reset();
    repeat (33) tick(1, 1, 0, 0);
    check("s2_hold", 64'({seed_valid, src_ready}), 64'(2'b10));
    check("s2_no_seed", 64'(seed_cnt), 64'(0));
    tick(0, 0, 1, 0);
    check("s2_seed_cnt", 64'(seed_cnt), 64'(1));

    // Scenario 3: health failure after chunk 5
    do_reset();
    tick(1, 0, 1, 0);
    repeat (5) tick(1, 1, 1, 0);
    tick(1, 0, 1, 1);
    repeat (8) tick(0, 1, 0, 0);
    check("s3_counts", 64'({seed_cnt, drop_cnt}), 64'(24'h0000_01));
    check("s3_idle", 64'(busy), 64'(0));

    // Scenario 4a: failure while offering without ready
    do_reset();
    repeat (13) tick(1, 1, 0, 0);
    check("s4_offer", 64'(seed_valid), 64'(1));
    tick(1, 0, 0, 1);
    check("s4_drop_valid", 64'(seed_valid), 64'(0));
    tick(0, 0, 0, 0);
    check("s4a_counts", 64'({seed_cnt, drop_cnt}), 64'(24'h0000_01));

    // Scenario 4b: failure in the handoff cycle
    do_reset();
    repeat (13) tick(1, 1, 0, 0);
    tick(0, 0, 1, 1);
    check("s4b_counts", 64'({seed_cnt, drop_cnt}), 64'(24'h0001_00));

    // Scenario 5: pause after chunk 4
    do_reset();
    tick(1, 0, 0, 0);
    repeat (4) tick(1, 1, 0, 0);
    repeat (10) tick(0, 1, 0, 0);
    check("s5_paused", 64'({src_ready, busy}), 64'(2'b01));
    check("s5_fill_cnt", 64'(dut.fill_cnt), 64'(4));
    repeat (8) tick(1, 1, 0, 0);
    check("s5_offer", 64'(seed_valid), 64'(1));

    // Scenario 6: reset mid-fill, then fresh batch, then mismatch
    do_reset();
    tick(1, 0, 0, 0);
    repeat (7) tick(1, 1, 1, 0);
    #2 rst_n = 0;
    #1;
    check("s6_async_reset",
          64'({src_ready, buf_enque, buf_deque, seed_valid, busy,
               sync_err, seed_cnt, drop_cnt}), 64'(0));
    repeat (2) tick(0, 0, 0, 0);
    rst_n = 1;
    tick(1, 0, 0, 0);
    repeat (11) tick(1, 1, 1, 0);
    check("s6_eleven", 64'(seed_valid), 64'(0));
    tick(1, 1, 1, 0);
    check("s6_twelve", 64'(seed_valid), 64'(1));
    tick(0, 0, 1, 0);
    check("s6_seed_cnt", 64'(seed_cnt), 64'(1));
    force_full = 1;
    tick(0, 0, 0, 0);
    force_full = 0;
    check("s6_sync_err", 64'(sync_err), 64'(1));
    repeat (3) tick(0, 0, 0, 0);
    check("s6_sync_sticky", 64'(sync_err), 64'(1));

    // Drop counter saturation
    do_reset();
    tick(1, 0, 0, 0);
    repeat (258) begin
      tick(1, 1, 0, 1);
      repeat (12) tick(1, 1, 0, 0);
    end
    check("drop_saturate", 64'(drop_cnt), 64'(8'hFF));

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        tick(0, 0, 0, 0);
        rst_n = 1;
      end
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    repeat (2) tick(0, 0, 0, 0);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
